bcd_serial_add_ctrl: RTL
========================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand, legal range 1..8.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to add; sampled only in IDLE.
REQ-005 Port: a  input  4*DIGITS  packed BCD operand A; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-006 Port: b  input  4*DIGITS  packed BCD operand B; same packing as a.
REQ-007 Port: busy  output  1  high while the block is in any state other than IDLE.
REQ-008 Port: done  output  1  one-cycle pulse; result outputs valid.
REQ-009 Port: sum  output  4*DIGITS  registered packed BCD result.
REQ-010 Port: co  output  1  registered decimal carry out of the most significant digit.
REQ-011 Port: n_err  output  1  registered error flag, active-low: 0 means an operand contained a non-BCD digit (1010..1111).

Function
REQ-012 The block SHALL implement FSM states IDLE, ADD and DONE, encoded and registered internally.
REQ-013 In IDLE with start=1, the block SHALL capture a and b into internal operand registers, clear the internal carry to 0 and the digit index to 0 on the same edge.
REQ-014 On that capture edge, if every digit of a and b is 0000..1001, the block SHALL enter ADD; otherwise it SHALL enter DONE directly with sum=0, co=0 and n_err=0 loaded.
REQ-015 In ADD, each cycle SHALL process exactly one digit pair, index i from 0 upward: t = a_i + b_i + carry (5-bit); if t > 9 then digit = (t + 6) mod 16 and carry = 1, else digit = t and carry = 0.
REQ-016 Each digit result SHALL be stored at position i of an internal work register; i SHALL increment by 1 per ADD cycle.
REQ-017 On the edge that processes digit DIGITS-1, the block SHALL enter DONE and load sum from the completed work register, co from the final carry, and n_err=1.
REQ-018 Latency for valid operands: done SHALL be high in the cycle beginning DIGITS+1 rising edges after the edge that sampled start.
REQ-019 Latency for invalid operands: done SHALL be high in the cycle beginning 1 rising edge after the edge that sampled start.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 sum, co and n_err SHALL change only on the edge entering DONE, or on reset, and SHALL hold until the next result is loaded.
REQ-022 start SHALL be ignored in ADD and DONE; changes of a or b after the capture edge SHALL NOT affect the result.
REQ-023 A start held high continuously SHALL launch a new operation on the first IDLE cycle after DONE, i.e. back-to-back operations every DIGITS+2 cycles.
REQ-024 busy SHALL be 0 in IDLE and 1 in ADD and DONE.
REQ-025 Carry into digit 0 SHALL always be 0; a carry out of digit DIGITS-1 SHALL appear only on co and SHALL NOT wrap into sum.

Reset
REQ-026 With rst=1 at a rising edge, the block SHALL enter IDLE and load busy=0, done=0, sum=0, co=0 and n_err=1; internal carry, index and work registers SHALL be 0.
REQ-027 rst SHALL take priority over start and over any in-progress operation; an operation interrupted by reset SHALL NOT produce a done pulse.

Verification (DIGITS=4)
REQ-028 a=1234, b=5678, 1-cycle start -> done 5 cycles later, sum=6912, co=0, n_err=1; busy high for 5 cycles.
REQ-029 a=9999, b=0001 -> sum=0000, co=1, n_err=1 (full ripple carry through all digits).
REQ-030 a=9999, b=9999 -> sum=9998, co=1, n_err=1 (maximum per-digit sum 19).
REQ-031 a=12A4, b=0001 -> done 1 cycle after start, sum=0000, co=0, n_err=0; a following valid add restores n_err=1.
REQ-032 Start with 1234+5678, then re-pulse start with 1111+1111 during ADD -> second request ignored, result 6912; start held high -> second operation begins the cycle after DONE.
REQ-033 rst=1 during the 2nd ADD cycle -> next cycle IDLE, busy=0, sum=0, co=0, n_err=1, no done pulse.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Digit-serial packed-BCD adder. When start is seen in IDLE, both operands
// are captured. One digit pair is then added per cycle, least significant
// digit first, with decimal carry. The result is published together with a
// one-cycle done pulse.
//
// If either operand holds a non-BCD digit (1010..1111), the block skips the
// ADD phase. It goes straight to DONE with sum=0, co=0 and n_err=0.
//
// Handshake: start is a level request sampled only in IDLE. busy is high
// from the capture edge until the cycle after done. done is a single-cycle
// pulse, and sum/co/n_err are valid from that cycle until the next result
// is loaded. A start held high relaunches on the first IDLE cycle after
// DONE.
//
// Ports
//   clk    in   1         rising-edge clock
//   rst    in   1         synchronous active-high reset
//   start  in   1         add request (IDLE only)
//   a, b   in   4*DIGITS  packed BCD operands, digit 0 in bits [3:0]
//   busy   out  1         high outside IDLE
//   done   out  1         one-cycle result-valid pulse
//   sum    out  4*DIGITS  registered packed BCD sum
//   co     out  1         registered decimal carry out of the top digit
//   n_err  out  1         registered error flag, 0 = operand was not BCD
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                co,
  output logic                n_err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  work;
  logic [IW-1:0] idx;
  logic          carry;

  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [4:0]    t;
  logic [3:0]    digit;
  logic          carry_nxt;
  logic [W-1:0]  work_nxt;
  logic          last;
  logic          ops_valid;

  function automatic logic all_bcd(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign ops_valid = all_bcd(a) && all_bcd(b);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign last      = (idx == IW'(DIGITS - 1));

  // One digit slice of the adder.
  // A raw sum above 9 is corrected by +6, which wraps the nibble past 15.
  // The new digit is merged into a copy of the work register. This lets the
  // final edge load sum with every digit already in place.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        dig_a = op_a[4*i +: 4];
        dig_b = op_b[4*i +: 4];
      end
    end
    t = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry};
    if (t > 5'd9) begin
      digit     = 4'(t + 5'd6);
      carry_nxt = 1'b1;
    end else begin
      digit     = t[3:0];
      carry_nxt = 1'b0;
    end
    work_nxt = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) work_nxt[4*i +: 4] = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      n_err <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            work  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            if (ops_valid) begin
              state <= S_ADD;
            end else begin
              state <= S_DONE;
              sum   <= '0;
              co    <= 1'b0;
              n_err <= 1'b0;
            end
          end
        end
        S_ADD: begin
          work  <= work_nxt;
          carry <= carry_nxt;
          idx   <= idx + IW'(1);
          if (last) begin
            // The top digit's carry goes to co only; sum never wraps.
            state <= S_DONE;
            sum   <= work_nxt;
            co    <= carry_nxt;
            n_err <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
